// File: rtl/vga_sync_rx.sv
// -----------------------------------------------------------------------------
// vga_sync_rx
//   Receives VGA-style timing (hsync, vsync, de), produces registered active
//   pixel coordinates, measures line/frame timing and reports whether the
//   incoming timing is stable and matches the expected H_DISP x V_DISP.
//
// Parameters
//   H_DISP    expected active pixels per line
//   V_DISP    expected active lines per frame
//   SYNC_POL  active level of hsync/vsync (0 = active-low)
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   hsync        in   horizontal sync
//   vsync        in   vertical sync
//   de           in   display enable, high during active pixels
//   x, y         out  active-pixel column / row (saturate at 4095)
//   pix_valid    out  x/y qualify an active pixel (2 clk after de)
//   frame_start  out  one-cycle pulse at vsync leading edge
//   h_total      out  measured clocks per line
//   v_total      out  measured lines per frame
//   locked       out  timing stable and matching H_DISP x V_DISP
//   err          out  one-cycle pulse on lock loss
//   err_cnt      out  saturating lock-loss counter
//
// Build option
//   VGA_SYNC_RX_ERRCNT_EN  when defined, err_cnt counts err pulses
//                          (saturating at 255); otherwise err_cnt is 0.
// -----------------------------------------------------------------------------
module vga_sync_rx #(
  parameter int H_DISP   = 1280,
  parameter int V_DISP   = 1024,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [11:0] v_total,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [11:0] LP_H   = 12'(H_DISP);
  localparam logic [11:0] LP_V   = 12'(V_DISP);
  localparam logic [11:0] LP_MAX = 12'hFFF;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      r_state, w_state_next;
  logic        r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
  logic [11:0] r_x, r_y, r_hcnt, r_h_total, r_lcnt, r_v_total;
  logic [11:0] r_wcnt, r_last_w, r_act_lines;
  logic [11:0] r_snap_h, r_snap_v, r_snap_w, r_snap_ht;
  logic        r_pv, r_fs, r_y_run, r_h_bad, r_seen_vs, r_err;

  logic        w_hs_rise, w_vs_rise, w_de_rise, w_de_fall, w_eval, w_err;
  logic        w_h_bad_now, w_fmt_ok, w_same;
  logic [11:0] w_lcnt_inc, w_act_inc, w_h_now;

  // Syncs are normalised to "1 = asserted" on entry to stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2} <= '0;
    end else begin
      r_hs1 <= (hsync == SYNC_POL);
      r_vs1 <= (vsync == SYNC_POL);
      r_de1 <= de;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_de2 <= r_de1;
    end
  end

  assign w_hs_rise = r_hs1 & ~r_hs2;
  assign w_vs_rise = r_vs1 & ~r_vs2;
  assign w_de_rise = r_de1 & ~r_de2;
  assign w_de_fall = ~r_de1 & r_de2;

  // Pixel coordinates. r_y_run is clear until the first active line of a
  // frame has started, so that line is numbered 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_pv    <= 1'b0;
      r_fs    <= 1'b0;
      r_y_run <= 1'b0;
    end else begin
      r_pv <= r_de1;
      r_fs <= w_vs_rise;
      if (w_de_rise) r_x <= '0;
      else if (r_de1 && r_x != LP_MAX) r_x <= r_x + 12'd1;
      if (w_de_rise) begin
        if (!r_y_run) r_y <= '0;
        else if (r_y != LP_MAX) r_y <= r_y + 12'd1;
        r_y_run <= 1'b1;
      end
      if (w_vs_rise) r_y_run <= 1'b0;
    end
  end

  // Line count and active-line count including any edge in this cycle, so a
  // coincident hsync edge is counted before vsync captures the total.
  assign w_lcnt_inc = (w_hs_rise && r_lcnt != LP_MAX) ? r_lcnt + 12'd1 : r_lcnt;
  assign w_act_inc  = (w_de_rise && r_act_lines != LP_MAX) ? r_act_lines + 12'd1 : r_act_lines;
  assign w_h_now    = w_hs_rise ? r_hcnt : r_h_total;
  // A line whose length differs from the previous one marks the frame unstable.
  assign w_h_bad_now = r_h_bad | (w_hs_rise && r_hcnt != r_h_total);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt      <= '0;
      r_h_total   <= '0;
      r_lcnt      <= '0;
      r_v_total   <= '0;
      r_wcnt      <= '0;
      r_last_w    <= '0;
      r_act_lines <= '0;
      r_h_bad     <= 1'b0;
      r_seen_vs   <= 1'b0;
    end else begin
      // Counter reads 1 on the edge cycle, so the value seen at the next edge
      // is the full line length.
      if (w_hs_rise) begin
        r_h_total <= r_hcnt;
        r_hcnt    <= 12'd1;
      end else if (r_hcnt != LP_MAX) begin
        r_hcnt <= r_hcnt + 12'd1;
      end
      if (w_de_rise) r_wcnt <= 12'd1;
      else if (r_de1 && r_wcnt != LP_MAX) r_wcnt <= r_wcnt + 12'd1;
      if (w_de_fall) r_last_w <= r_wcnt;
      if (w_vs_rise) begin
        r_v_total   <= w_lcnt_inc;
        r_lcnt      <= '0;
        r_act_lines <= '0;
        r_h_bad     <= 1'b0;
        r_seen_vs   <= 1'b1;
      end else begin
        r_lcnt      <= w_lcnt_inc;
        r_act_lines <= w_act_inc;
        r_h_bad     <= w_h_bad_now;
      end
    end
  end

  // The first vsync edge after reset closes a partial frame: not evaluated.
  assign w_eval   = w_vs_rise & r_seen_vs;
  assign w_fmt_ok = (r_last_w == LP_H) && (w_act_inc == LP_V) && !w_h_bad_now;
  assign w_same   = (w_h_now == r_snap_h) && (w_lcnt_inc == r_snap_v) &&
                    (r_last_w == r_snap_w) && (w_act_inc == r_snap_ht);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEARCH;
      r_err     <= 1'b0;
      r_snap_h  <= '0;
      r_snap_v  <= '0;
      r_snap_w  <= '0;
      r_snap_ht <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err;
      if (w_eval) begin
        r_snap_h  <= w_h_now;
        r_snap_v  <= w_lcnt_inc;
        r_snap_w  <= r_last_w;
        r_snap_ht <= w_act_inc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    if (w_eval) begin
      case (r_state)
        SEARCH: if (w_fmt_ok) w_state_next = CHECK;
        CHECK:  w_state_next = (w_fmt_ok && w_same) ? LOCKED : SEARCH;
        LOCKED: begin
          if (!(w_fmt_ok && w_same)) begin
            w_state_next = SEARCH;
            w_err        = 1'b1;
          end
        end
        default: w_state_next = SEARCH;
      endcase
    end
  end

`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= '0;
    else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

  assign x           = r_x;
  assign y           = r_y;
  assign pix_valid   = r_pv;
  assign frame_start = r_fs;
  assign h_total     = r_h_total;
  assign v_total     = r_v_total;
  assign locked      = (r_state == LOCKED);
  assign err         = r_err;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx with a 16x8 display:
// H 16 active / 2 front / 4 sync / 6 back (28 clk), V 8 / 1 / 2 / 3 (14 lines).
// vsync asserts together with the hsync edge of line 9.
module tb_vga_sync_rx;
  logic        clk = 1'b0;
  logic        rst_n, hsync, vsync, de;
  logic [11:0] x, y, h_total, v_total;
  logic        pix_valid, frame_start, locked, err;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  // monitor state
  int cyc = 0, de_rise_cyc = 0, de_len = 0;
  int pv_cnt = 0, seq_bad = 0, lat_bad = 0, len_bad = 0, run = 0;
  int err_seen = 0, fs_seen = 0;
  logic [11:0] last_x = 0, last_y = 0, exp_x, exp_y;
  logic prev_pv = 0, expect_y0 = 1;

  // snapshot taken just after a mid-frame reset assertion
  logic [11:0] s_x, s_y, s_ht, s_vt;
  logic        s_pv, s_lk, s_err;
  logic [7:0]  s_ec;

  vga_sync_rx #(.H_DISP(16), .V_DISP(8), .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .pix_valid(pix_valid), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total), .locked(locked), .err(err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (err) err_seen++;
    if (frame_start) fs_seen++;
    if (pix_valid) begin
      pv_cnt++;
      if (!prev_pv) begin
        exp_x = 0;
        exp_y = expect_y0 ? 12'd0 : last_y + 12'd1;
        expect_y0 = 0;
        if (cyc - de_rise_cyc != 2) lat_bad++;
        run = 0;
      end else begin
        exp_x = last_x + 12'd1;
        exp_y = last_y;
      end
      if (x !== exp_x || y !== exp_y) seq_bad++;
      last_x = x;
      last_y = y;
      run++;
    end else if (prev_pv && run != de_len) begin
      len_bad++;
    end
    if (frame_start || !rst_n) expect_y0 = 1;
    prev_pv = pix_valid;
  end

  task automatic frame(input int act, input int stretch, input int rst_line);
    int  ex;
    logic de_n;
    for (int l = 0; l < 14; l++) begin
      ex = (l == stretch) ? 1 : 0;
      for (int c = 0; c < 28 + ex; c++) begin
        @(negedge clk);
        de_n = (l < 8) && (c < act);
        if (de_n && !de) begin
          de_rise_cyc = cyc;
          de_len = act;
        end
        de    = de_n;
        hsync = !(c >= 18 + ex && c < 22 + ex);
        vsync = !((l == 9 && c >= 18 + ex) || l == 10 || (l == 11 && c < 18 + ex));
        if (l == rst_line && c == 20) begin
          rst_n = 1'b0;
          #1;
          s_x = x; s_y = y; s_ht = h_total; s_vt = v_total;
          s_pv = pix_valid; s_lk = locked; s_err = err; s_ec = err_cnt;
        end
        if (l == rst_line && c == 23) rst_n = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (x !== 12'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", x); end
    total++; if (y !== 12'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", y); end
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pv got=%b want=0", pix_valid); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    total++; if (h_total !== 12'd0 || v_total !== 12'd0) begin bad++; $display("FAIL reset_totals got=%0d/%0d want=0/0", h_total, v_total); end
    total++; if (locked !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_lock got=%b/%b want=0/0", locked, err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_cnt); end
    $display("reset: x=%0d y=%0d locked=%b", x, y, locked);
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    frame(16, -1, -1);
    frame(16, -1, -1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_after2 got=%b want=0", locked); end
    total++; if (fs_seen != 2) begin bad++; $display("FAIL frame_start_count got=%0d want=2", fs_seen); end
    frame(16, -1, -1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_after3 got=%b want=1", locked); end
    total++; if (h_total !== 12'd28) begin bad++; $display("FAIL h_total got=%0d want=28", h_total); end
    total++; if (v_total !== 12'd14) begin bad++; $display("FAIL v_total got=%0d want=14", v_total); end
    total++; if (err_seen != 0) begin bad++; $display("FAIL lock_no_err got=%0d want=0", err_seen); end
    $display("lock: locked=%b h_total=%0d v_total=%0d", locked, h_total, v_total);
  endtask

  task automatic test_pixels;
    pv_cnt = 0;
    frame(16, -1, -1);
    total++; if (pv_cnt != 128) begin bad++; $display("FAIL pix_count got=%0d want=128", pv_cnt); end
    total++; if (last_x !== 12'd15 || last_y !== 12'd7) begin bad++; $display("FAIL last_pixel got=%0d,%0d want=15,7", last_x, last_y); end
    total++; if (seq_bad != 0) begin bad++; $display("FAIL xy_sequence got=%0d errors want=0", seq_bad); end
    total++; if (lat_bad != 0) begin bad++; $display("FAIL pv_latency got=%0d errors want=0", lat_bad); end
    total++; if (len_bad != 0) begin bad++; $display("FAIL pv_length got=%0d errors want=0", len_bad); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_hold got=%b want=1", locked); end
    $display("pixels: count=%0d last=(%0d,%0d)", pv_cnt, last_x, last_y);
  endtask

  task automatic test_stretch;
    int e0;
    logic [7:0] ec_exp;
`ifdef VGA_SYNC_RX_ERRCNT_EN
    ec_exp = 8'd1;
`else
    ec_exp = 8'd0;
`endif
    e0 = err_seen;
    frame(16, 3, -1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL stretch_lock got=%b want=0", locked); end
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL stretch_err got=%0d pulses want=1", err_seen - e0); end
    total++; if (err_cnt !== ec_exp) begin bad++; $display("FAIL stretch_errcnt got=%0d want=%0d", err_cnt, ec_exp); end
    frame(16, -1, -1);
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL stretch_err_once got=%0d pulses want=1", err_seen - e0); end
    $display("stretch: locked=%b err_pulses=%0d err_cnt=%0d", locked, err_seen - e0, err_cnt);
  endtask

  task automatic test_reset_mid;
    frame(16, -1, 2);
    total++; if (s_x !== 12'd0 || s_y !== 12'd0 || s_pv !== 1'b0) begin bad++; $display("FAIL midrst_xy got=%0d,%0d,%b want=0,0,0", s_x, s_y, s_pv); end
    total++; if (s_ht !== 12'd0 || s_vt !== 12'd0) begin bad++; $display("FAIL midrst_totals got=%0d/%0d want=0/0", s_ht, s_vt); end
    total++; if (s_lk !== 1'b0 || s_err !== 1'b0 || s_ec !== 8'd0) begin bad++; $display("FAIL midrst_flags got=%b/%b/%0d want=0/0/0", s_lk, s_err, s_ec); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_lockA got=%b want=0", locked); end
    frame(16, -1, -1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_lockB got=%b want=0", locked); end
    frame(16, -1, -1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL midrst_lockC got=%b want=1", locked); end
    $display("reset_mid: locked=%b", locked);
  endtask

  task automatic test_short;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame(15, -1, -1);
    frame(15, -1, -1);
    pv_cnt = 0;
    frame(15, -1, -1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_lock got=%b want=0", locked); end
    total++; if (pv_cnt != 120) begin bad++; $display("FAIL short_count got=%0d want=120", pv_cnt); end
    total++; if (last_x !== 12'd14) begin bad++; $display("FAIL short_last_x got=%0d want=14", last_x); end
    $display("short: locked=%b count=%0d last_x=%0d", locked, pv_cnt, last_x);
  endtask

  initial begin
    test_reset;
    test_lock;
    test_pixels;
    test_stretch;
    test_reset_mid;
    test_short;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
